agen_lsu_pipe: RTL and testbench

Parametrised AGEN-to-LSU pipeline with DEPTH stages, LANES lockstep lanes and elastic backpressure from the LSU. Each lane carries a packet whose top CHECKPOINTS bits are a branch mask. Packets are squashed in flight on a branch mispredict. Their mask bits are cleared in flight when a branch resolves correctly. Sits between the address-generation units and the load-store unit.

---
 rtl/agen_lsu_pipe.sv | 127 ++++++++++++
 tb/tb_agen_lsu_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/agen_lsu_pipe.sv
// AGEN-to-LSU elastic pipeline: DEPTH stages of LANES lockstep lanes with in-flight branch squash/resolve.
// Optional AGEN_LSU_VERIFY_EN: zero the payload of every lane whose valid is 0.
module agen_lsu_pipe #(
   parameter int PKT_W           = 96,
   parameter int CHECKPOINTS     = 8,
   parameter int CHECKPOINTS_LOG = 3,
   parameter int LANES           = 2,
   parameter int DEPTH           = 2
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      ctrlMispredict_i,
   input  logic [CHECKPOINTS_LOG-1:0]                ctrlSMTid_i,
   input  logic                                      ctrlResolve_i,
   input  logic [CHECKPOINTS_LOG-1:0]                ctrlResolveId_i,
   input  logic [LANES*(CHECKPOINTS+PKT_W)-1:0]      exePacket_i,
   input  logic [LANES-1:0]                          exePacketValid_i,
   output logic                                      agenReady_o,
   output logic [LANES*(CHECKPOINTS+PKT_W)-1:0]      agenPacket_o,
   output logic [LANES-1:0]                          agenPacketValid_o,
   input  logic                                      lsuReady_i
);

   localparam int LW = CHECKPOINTS + PKT_W;
   localparam int DW = LANES * LW;

   // Handshake: a beat moves across a boundary on a rising edge when the sender
   // holds any valid lane and the receiver is ready; ready never depends on the
   // sender's valid, and the sender must hold its beat until it sees ready.

   logic [DEPTH-1:0][LANES-1:0] r_valid;
   logic [DEPTH-1:0][DW-1:0]    r_data;

   logic [DEPTH-1:0][LANES-1:0] w_eff;
   logic [DEPTH-1:0][DW-1:0]    w_res;
   logic [DEPTH:0][LANES-1:0]   w_src_v;
   logic [DEPTH:0][DW-1:0]      w_src_d;
   logic [DEPTH-1:0]            w_occ;
   logic [DEPTH-1:0]            w_adv;
   logic [DEPTH:0]              w_go;
   logic [DEPTH-1:0][LANES-1:0] w_nxt_v;
   logic [DEPTH-1:0][DW-1:0]    w_nxt_d;
   logic [CHECKPOINTS-1:0]      w_keep;
   logic [LANES-1:0]            w_kill_mask;

   function automatic logic [LANES-1:0] f_hit(input logic [DW-1:0] d,
                                             input logic [CHECKPOINTS_LOG-1:0] id);
      logic [LANES-1:0]       h;
      logic [CHECKPOINTS-1:0] m;
      h = '0;
      for (int l = 0; l < LANES; l++) begin
         m    = d[l*LW+PKT_W +: CHECKPOINTS];
         h[l] = m[id];
      end
      return h;
   endfunction

   function automatic logic [DW-1:0] f_clr(input logic [DW-1:0] d,
                                          input logic [CHECKPOINTS-1:0] keep);
      logic [DW-1:0] r;
      r = d;
      for (int l = 0; l < LANES; l++) begin
         r[l*LW+PKT_W +: CHECKPOINTS] = d[l*LW+PKT_W +: CHECKPOINTS] & keep;
      end
      return r;
   endfunction

   always_comb begin
      w_keep      = ctrlResolve_i ? ~(CHECKPOINTS'(1) << ctrlResolveId_i) : '1;
      w_kill_mask = {LANES{ctrlMispredict_i}};
      w_eff       = '0;
      w_res       = '0;
      w_occ       = '0;
      w_adv       = '0;
      w_go        = '0;
      w_nxt_v     = '0;
      w_nxt_d     = '0;

      // Squash uses the pre-resolve mask, so a mispredict beats a same-id resolve.
      w_src_v[0] = exePacketValid_i & ~(f_hit(exePacket_i, ctrlSMTid_i) & w_kill_mask);
      w_src_d[0] = f_clr(exePacket_i, w_keep);
      for (int k = 0; k < DEPTH; k++) begin
         w_eff[k]     = r_valid[k] & ~(f_hit(r_data[k], ctrlSMTid_i) & w_kill_mask);
         w_res[k]     = f_clr(r_data[k], w_keep);
         w_occ[k]     = |w_eff[k];
         w_src_v[k+1] = w_eff[k];
         w_src_d[k+1] = w_res[k];
      end

      // Occupancy is taken after this cycle's squash, so a fully squashed stage frees its slot now.
      w_go[DEPTH] = lsuReady_i;
      for (int k = DEPTH-1; k >= 0; k--) begin
         w_adv[k] = w_occ[k] & w_go[k+1];
         w_go[k]  = ~w_occ[k] | w_adv[k];
      end

      for (int k = 0; k < DEPTH; k++) begin
         if (w_go[k]) begin
            w_nxt_v[k] = w_src_v[k];
            w_nxt_d[k] = w_src_d[k];
         end else begin
            w_nxt_v[k] = w_eff[k];
            w_nxt_d[k] = w_res[k];
         end
`ifdef AGEN_LSU_VERIFY_EN
         for (int l = 0; l < LANES; l++) begin
            if (!w_nxt_v[k][l]) w_nxt_d[k][l*LW +: LW] = '0;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_valid <= '0;
         r_data  <= '0;
      end else begin
         r_valid <= w_nxt_v;
         r_data  <= w_nxt_d;
      end
   end

   assign agenReady_o       = w_go[0];
   assign agenPacket_o      = r_data[DEPTH-1];
   assign agenPacketValid_o = w_eff[DEPTH-1];

endmodule

// File: tb/tb_agen_lsu_pipe.sv
// Directed bench for agen_lsu_pipe (DEPTH=2, LANES=2): latency, backpressure, squash, resolve, async reset.
module tb_agen_lsu_pipe;
  localparam int PKT_W = 96;
  localparam int CP    = 8;
  localparam int LW    = CP + PKT_W;
  localparam int DW    = 2 * LW;

  logic          clk;
  logic          reset;
  logic          misp;
  logic [2:0]    misp_id;
  logic          res;
  logic [2:0]    res_id;
  logic [DW-1:0] pkt_in;
  logic [1:0]    vld_in;
  logic          ready_o;
  logic [DW-1:0] pkt_o;
  logic [1:0]    vld_o;
  logic          lsu_rdy;

  int n_total;
  int n_bad;
  logic [DW-1:0] exp_q[$];

  agen_lsu_pipe #(.PKT_W(PKT_W), .CHECKPOINTS(CP), .CHECKPOINTS_LOG(3), .LANES(2), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .ctrlMispredict_i(misp), .ctrlSMTid_i(misp_id),
    .ctrlResolve_i(res), .ctrlResolveId_i(res_id),
    .exePacket_i(pkt_in), .exePacketValid_i(vld_in),
    .agenReady_o(ready_o), .agenPacket_o(pkt_o), .agenPacketValid_o(vld_o),
    .lsuReady_i(lsu_rdy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [LW-1:0] mk(input logic [CP-1:0] m, input logic [PKT_W-1:0] p);
    return {m, p};
  endfunction

  function automatic logic [DW-1:0] beat(input int n);
    return {mk(8'h00, PKT_W'(32'h200 + n)), mk(8'h00, PKT_W'(32'h100 + n))};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    misp = 1'b0; misp_id = '0; res = 1'b0; res_id = '0;
    pkt_in = '0; vld_in = '0;
  endtask

  task automatic flush();
    idle_inputs();
    lsu_rdy = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_reset();
    n_total++; if (vld_o !== 2'b00) begin n_bad++; $display("FAIL reset_valid got=%b want=00", vld_o); end
    n_total++; if (pkt_o !== '0) begin n_bad++; $display("FAIL reset_packet got=%h want=0", pkt_o); end
    n_total++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
  endtask

  task automatic test_latency();
    lsu_rdy = 1'b1;
    pkt_in = {mk(8'h00, '0), mk(8'h00, PKT_W'(8'hA5))};
    vld_in = 2'b01;
    step();
    idle_inputs();
    #1;
    n_total++; if (vld_o !== 2'b00) begin n_bad++; $display("FAIL lat_cycle1_valid got=%b want=00", vld_o); end
    n_total++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL lat_cycle1_ready got=%b want=1", ready_o); end
    step();
    n_total++; if (vld_o !== 2'b01) begin n_bad++; $display("FAIL lat_cycle2_valid got=%b want=01", vld_o); end
    n_total++; if (pkt_o[LW-1:0] !== mk(8'h00, PKT_W'(8'hA5))) begin n_bad++; $display("FAIL lat_payload got=%h want=a5", pkt_o[LW-1:0]); end
    n_total++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL lat_cycle2_ready got=%b want=1", ready_o); end
    step();
    n_total++; if (vld_o !== 2'b00) begin n_bad++; $display("FAIL lat_cycle3_valid got=%b want=00", vld_o); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy [4];
    int n;
    int drained;
    logic [DW-1:0] exp;
    exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
    n = 0;
    drained = 0;
    exp_q.delete();
    lsu_rdy = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pkt_in = beat(n); vld_in = 2'b11;
      #1;
      n_total++; if (ready_o !== exp_rdy[c]) begin n_bad++; $display("FAIL bp_ready cycle=%0d got=%b want=%b", c, ready_o, exp_rdy[c]); end
      if (ready_o) begin exp_q.push_back(beat(n)); n++; end
      step();
    end
    n_total++; if (vld_o !== 2'b11) begin n_bad++; $display("FAIL bp_stall_valid got=%b want=11", vld_o); end
    for (int c = 0; c < 8; c++) begin
      lsu_rdy = 1'b1;
      if (n < 3) begin pkt_in = beat(n); vld_in = 2'b11; end
      else begin pkt_in = '0; vld_in = 2'b00; end
      #1;
      if (vld_o !== 2'b00) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL bp_extra_beat got=%h want=none", pkt_o);
        end else begin
          exp = exp_q.pop_front();
          drained++;
          if (pkt_o !== exp || vld_o !== 2'b11) begin
            n_bad++; $display("FAIL bp_order got=%h/%b want=%h/11", pkt_o, vld_o, exp);
          end
        end
      end
      if (ready_o && n < 3) begin exp_q.push_back(beat(n)); n++; end
      step();
    end
    n_total++; if (drained != 3 || exp_q.size() != 0) begin n_bad++; $display("FAIL bp_drain_count got=%0d left=%0d want=3/0", drained, exp_q.size()); end
    idle_inputs();
  endtask

  task automatic test_mispredict();
    flush();
    lsu_rdy = 1'b0;
    pkt_in = {mk(8'h00, '0), mk(8'h04, PKT_W'(8'h11))}; vld_in = 2'b01;
    step();
    pkt_in = {mk(8'h00, '0), mk(8'h00, PKT_W'(8'h22))}; vld_in = 2'b01;
    step();
    idle_inputs();
    #1;
    n_total++; if (vld_o !== 2'b01) begin n_bad++; $display("FAIL misp_pre_valid got=%b want=01", vld_o); end
    n_total++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL misp_pre_ready got=%b want=0", ready_o); end
    misp = 1'b1; misp_id = 3'd2;
    #1;
    n_total++; if (vld_o !== 2'b00) begin n_bad++; $display("FAIL misp_same_cycle got=%b want=00", vld_o); end
    n_total++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL misp_freed_ready got=%b want=1", ready_o); end
    step();
    idle_inputs();
    #1;
    n_total++; if (vld_o !== 2'b01) begin n_bad++; $display("FAIL misp_next_valid got=%b want=01", vld_o); end
    n_total++; if (pkt_o[LW-1:0] !== mk(8'h00, PKT_W'(8'h22))) begin n_bad++; $display("FAIL misp_advance got=%h want=22", pkt_o[LW-1:0]); end
  endtask

  task automatic test_resolve();
    flush();
    lsu_rdy = 1'b0;
    pkt_in = {mk(8'h00, '0), mk(8'h06, PKT_W'(8'h33))}; vld_in = 2'b01;
    step();
    idle_inputs();
    step();
    n_total++; if (pkt_o[LW-1:PKT_W] !== 8'h06) begin n_bad++; $display("FAIL res_pre_mask got=%h want=06", pkt_o[LW-1:PKT_W]); end
    res = 1'b1; res_id = 3'd1;
    #1;
    n_total++; if (pkt_o[LW-1:PKT_W] !== 8'h06) begin n_bad++; $display("FAIL res_same_cycle_mask got=%h want=06", pkt_o[LW-1:PKT_W]); end
    step();
    idle_inputs();
    #1;
    n_total++; if (pkt_o[LW-1:PKT_W] !== 8'h04) begin n_bad++; $display("FAIL res_next_mask got=%h want=04", pkt_o[LW-1:PKT_W]); end
    misp = 1'b1; misp_id = 3'd1;
    #1;
    n_total++; if (vld_o !== 2'b01) begin n_bad++; $display("FAIL res_misp_survive got=%b want=01", vld_o); end
    step();
    idle_inputs();
    #1;
    n_total++; if (vld_o !== 2'b01) begin n_bad++; $display("FAIL res_misp_after got=%b want=01", vld_o); end
  endtask

  task automatic test_both_same_id();
    flush();
    lsu_rdy = 1'b0;
    pkt_in = {mk(8'h00, PKT_W'(8'h55)), mk(8'h08, PKT_W'(8'h44))}; vld_in = 2'b11;
    step();
    idle_inputs();
    step();
    misp = 1'b1; misp_id = 3'd3; res = 1'b1; res_id = 3'd3;
    #1;
    n_total++; if (vld_o !== 2'b10) begin n_bad++; $display("FAIL same_id_now got=%b want=10", vld_o); end
    step();
    idle_inputs();
    #1;
    n_total++; if (vld_o !== 2'b10) begin n_bad++; $display("FAIL same_id_next got=%b want=10", vld_o); end
    n_total++; if (pkt_o[DW-1:LW] !== mk(8'h00, PKT_W'(8'h55))) begin n_bad++; $display("FAIL same_id_lane1 got=%h want=55", pkt_o[DW-1:LW]); end
`ifdef AGEN_LSU_VERIFY_EN
    n_total++; if (pkt_o[LW-1:0] !== '0) begin n_bad++; $display("FAIL same_id_zeroed got=%h want=0", pkt_o[LW-1:0]); end
`endif
  endtask

  task automatic test_both_diff_id();
    flush();
    lsu_rdy = 1'b0;
    pkt_in = {mk(8'h01, PKT_W'(8'h77)), mk(8'h06, PKT_W'(8'h66))}; vld_in = 2'b11;
    step();
    idle_inputs();
    step();
    misp = 1'b1; misp_id = 3'd0; res = 1'b1; res_id = 3'd1;
    step();
    idle_inputs();
    #1;
    n_total++; if (vld_o !== 2'b01) begin n_bad++; $display("FAIL diff_id_valid got=%b want=01", vld_o); end
    n_total++; if (pkt_o[LW-1:0] !== mk(8'h04, PKT_W'(8'h66))) begin n_bad++; $display("FAIL diff_id_lane0 got=%h want=04/66", pkt_o[LW-1:0]); end
  endtask

  task automatic test_capture_squash();
    flush();
    lsu_rdy = 1'b1;
    pkt_in = {mk(8'h20, PKT_W'(8'h99)), mk(8'h10, PKT_W'(8'h88))}; vld_in = 2'b11;
    misp = 1'b1; misp_id = 3'd4; res = 1'b1; res_id = 3'd5;
    step();
    idle_inputs();
    step();
    n_total++; if (vld_o !== 2'b10) begin n_bad++; $display("FAIL cap_valid got=%b want=10", vld_o); end
    n_total++; if (pkt_o[DW-1:LW] !== mk(8'h00, PKT_W'(8'h99))) begin n_bad++; $display("FAIL cap_lane1 got=%h want=00/99", pkt_o[DW-1:LW]); end
  endtask

  task automatic test_async_reset();
    flush();
    lsu_rdy = 1'b0;
    pkt_in = beat(7); vld_in = 2'b11;
    step();
    step();
    idle_inputs();
    #2;
    reset = 1'b0;
    #1;
    n_total++; if (vld_o !== 2'b00) begin n_bad++; $display("FAIL areset_valid got=%b want=00", vld_o); end
    n_total++; if (pkt_o !== '0) begin n_bad++; $display("FAIL areset_packet got=%h want=0", pkt_o); end
    n_total++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL areset_ready got=%b want=1", ready_o); end
    @(negedge clk);
    reset = 1'b1;
    step();
    n_total++; if (vld_o !== 2'b00) begin n_bad++; $display("FAIL areset_after got=%b want=00", vld_o); end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    reset   = 1'b0;
    lsu_rdy = 1'b1;
    idle_inputs();
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    step();
    test_latency();
    test_back_to_back();
    test_mispredict();
    test_resolve();
    test_both_same_id();
    test_both_diff_id();
    test_capture_squash();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
